// File: rtl/csr_ex_ctrl_pkg.sv
// Shared constants for the exception/interrupt commit controller: ECODE values,
// wb_exc flag bit positions and the controller state type.
package csr_ex_ctrl_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam int unsigned EXC_ADEF = 4;
  localparam int unsigned EXC_INE  = 3;
  localparam int unsigned EXC_SYS  = 2;
  localparam int unsigned EXC_BRK  = 1;
  localparam int unsigned EXC_ALE  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRedirect,
    StDrain
  } ex_state_e;

endpackage

// File: rtl/csr_ex_ctrl.sv
// Resolves WB exception flags / interrupts / ERTN into one commit event, drives the
// csr_reg update strobes, and holds a redirect handshake followed by a drain window.
module csr_ex_ctrl
  import csr_ex_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_wb_valid,
  input  logic [31:0] i_wb_pc,
  input  logic [31:0] i_wb_vaddr_in,
  input  logic [4:0]  i_wb_exc,
  input  logic        i_wb_ertn,
  input  logic        i_has_int,
  input  logic [31:0] i_ex_entry,
  input  logic [31:0] i_ertn_entry,
  output logic        o_wb_ex,
  output logic [5:0]  o_wb_ecode,
  output logic [8:0]  o_wb_esubcode,
  output logic [31:0] o_wb_csr_pc,
  output logic [31:0] o_wb_vaddr,
  output logic        o_ertn_flush,
  output logic        o_wb_commit,
  output logic        o_pipe_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  input  logic        i_redirect_ready
);

  // Counter preload; the handshake cycle itself is not part of the drain window.
  localparam logic [3:0] DRAIN_INIT = 4'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

  ex_state_e   r_state;
  ex_state_e   w_state_d;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_d;
  logic        r_redirect_valid;
  logic        w_redirect_valid_d;
  logic [31:0] r_redirect_pc;
  logic [31:0] w_redirect_pc_d;

  logic        w_take_exc;
  logic [5:0]  w_sel_ecode;
  logic [31:0] w_sel_vaddr;

  logic        w_ex;
  logic        w_ertn_flush;
  logic        w_commit;
  logic        w_flush;
  logic [5:0]  w_ecode;
  logic [31:0] w_vaddr;
  logic [31:0] w_csr_pc;

  assign w_take_exc = i_has_int | (|i_wb_exc);

  // Priority encoder: INT > ADEF > INE > SYS > BRK > ALE.
  always_comb begin
    w_sel_ecode = ECODE_INT;
    w_sel_vaddr = '0;
    if (i_has_int) begin
      w_sel_ecode = ECODE_INT;
    end else if (i_wb_exc[EXC_ADEF]) begin
      w_sel_ecode = ECODE_ADEF;
      w_sel_vaddr = i_wb_pc;
    end else if (i_wb_exc[EXC_INE]) begin
      w_sel_ecode = ECODE_INE;
    end else if (i_wb_exc[EXC_SYS]) begin
      w_sel_ecode = ECODE_SYS;
    end else if (i_wb_exc[EXC_BRK]) begin
      w_sel_ecode = ECODE_BRK;
    end else if (i_wb_exc[EXC_ALE]) begin
      w_sel_ecode = ECODE_ALE;
      w_sel_vaddr = i_wb_vaddr_in;
    end
  end

  always_comb begin
    w_state_d          = r_state;
    w_cnt_d            = r_cnt;
    w_redirect_valid_d = r_redirect_valid;
    w_redirect_pc_d    = r_redirect_pc;
    w_ex               = 1'b0;
    w_ertn_flush       = 1'b0;
    w_commit           = 1'b0;
    w_flush            = 1'b0;
    w_ecode            = '0;
    w_vaddr            = '0;
    w_csr_pc           = '0;
    case (r_state)
      StIdle: begin
        if (i_wb_valid) begin
          if (w_take_exc) begin
            w_ex            = 1'b1;
            w_ecode         = w_sel_ecode;
            w_vaddr         = w_sel_vaddr;
            w_csr_pc        = i_wb_pc;
            w_redirect_pc_d = i_ex_entry;
          end else begin
            w_commit = 1'b1;
            if (i_wb_ertn) begin
              w_ertn_flush    = 1'b1;
              w_redirect_pc_d = i_ertn_entry;
            end
          end
          if (w_take_exc || i_wb_ertn) begin
            w_flush            = 1'b1;
            w_redirect_valid_d = 1'b1;
            w_state_d          = StRedirect;
          end
        end
      end
      StRedirect: begin
        w_flush = 1'b1;
        if (i_redirect_ready) begin
          w_redirect_valid_d = 1'b0;
          if (DRAIN_CYCLES == 0) begin
            w_state_d = StIdle;
          end else begin
            w_state_d = StDrain;
            w_cnt_d   = DRAIN_INIT;
          end
        end
      end
      StDrain: begin
        w_flush = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state          <= StIdle;
      r_cnt            <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_state          <= w_state_d;
      r_cnt            <= w_cnt_d;
      r_redirect_valid <= w_redirect_valid_d;
      r_redirect_pc    <= w_redirect_pc_d;
    end
  end

  assign o_wb_ex          = w_ex;
  assign o_wb_ecode       = w_ecode;
  assign o_wb_esubcode    = '0;
  assign o_wb_csr_pc      = w_csr_pc;
  assign o_wb_vaddr       = w_vaddr;
  assign o_ertn_flush     = w_ertn_flush;
  assign o_wb_commit      = w_commit;
  assign o_pipe_flush     = w_flush;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_csr_ex_ctrl.sv
// Bench for csr_ex_ctrl: two builds (DRAIN_CYCLES 2 and 0) share one stimulus stream and
// are compared every cycle against a blocked-cycle reference model, plus directed checks.
module tb_csr_ex_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_vaddr_in = '0;
  logic [4:0]  wb_exc = '0;
  logic        wb_ertn = 1'b0;
  logic        has_int = 1'b0;
  logic [31:0] ex_entry = 32'h1C008000;
  logic [31:0] ertn_entry = 32'h1C000200;
  logic        redirect_ready = 1'b0;

  logic        o_ex [2];
  logic [5:0]  o_ecode [2];
  logic [8:0]  o_esub [2];
  logic [31:0] o_csr_pc [2];
  logic [31:0] o_vaddr [2];
  logic        o_ertn [2];
  logic        o_commit [2];
  logic        o_flush [2];
  logic        o_rv [2];
  logic [31:0] o_rpc [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: redirect outstanding flag, captured target, drain cycles remaining.
  logic        m_wait [2];
  logic [31:0] m_rpc [2];
  int          m_drain [2];

  always #5 clk = ~clk;

  csr_ex_ctrl #(.DRAIN_CYCLES(2)) u_dut (
    .i_clk(clk), .i_resetn(resetn), .i_wb_valid(wb_valid), .i_wb_pc(wb_pc),
    .i_wb_vaddr_in(wb_vaddr_in), .i_wb_exc(wb_exc), .i_wb_ertn(wb_ertn), .i_has_int(has_int),
    .i_ex_entry(ex_entry), .i_ertn_entry(ertn_entry), .o_wb_ex(o_ex[0]),
    .o_wb_ecode(o_ecode[0]), .o_wb_esubcode(o_esub[0]), .o_wb_csr_pc(o_csr_pc[0]),
    .o_wb_vaddr(o_vaddr[0]), .o_ertn_flush(o_ertn[0]), .o_wb_commit(o_commit[0]),
    .o_pipe_flush(o_flush[0]), .o_redirect_valid(o_rv[0]), .o_redirect_pc(o_rpc[0]),
    .i_redirect_ready(redirect_ready)
  );

  csr_ex_ctrl #(.DRAIN_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_resetn(resetn), .i_wb_valid(wb_valid), .i_wb_pc(wb_pc),
    .i_wb_vaddr_in(wb_vaddr_in), .i_wb_exc(wb_exc), .i_wb_ertn(wb_ertn), .i_has_int(has_int),
    .i_ex_entry(ex_entry), .i_ertn_entry(ertn_entry), .o_wb_ex(o_ex[1]),
    .o_wb_ecode(o_ecode[1]), .o_wb_esubcode(o_esub[1]), .o_wb_csr_pc(o_csr_pc[1]),
    .o_wb_vaddr(o_vaddr[1]), .o_ertn_flush(o_ertn[1]), .o_wb_commit(o_commit[1]),
    .o_pipe_flush(o_flush[1]), .o_redirect_valid(o_rv[1]), .o_redirect_pc(o_rpc[1]),
    .i_redirect_ready(redirect_ready)
  );

  function automatic int drain_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic        blocked, is_ex, ev;
      logic [5:0]  ecode;
      logic [31:0] vaddr;
      blocked = m_wait[k] || (m_drain[k] > 0);
      is_ex   = !blocked && wb_valid && (has_int || (wb_exc != 5'd0));
      ev      = !blocked && wb_valid && (has_int || (wb_exc != 5'd0) || wb_ertn);
      ecode   = 6'h00;
      vaddr   = 32'h0;
      if (is_ex && !has_int) begin
        if (wb_exc[4])      begin ecode = 6'h08; vaddr = wb_pc; end
        else if (wb_exc[3]) ecode = 6'h0D;
        else if (wb_exc[2]) ecode = 6'h0B;
        else if (wb_exc[1]) ecode = 6'h0C;
        else                begin ecode = 6'h09; vaddr = wb_vaddr_in; end
      end
      chk("wb_ex",       k, 32'(o_ex[k]),     32'(is_ex));
      chk("wb_ecode",    k, 32'(o_ecode[k]),  32'(ecode));
      chk("wb_esubcode", k, 32'(o_esub[k]),   32'h0);
      chk("wb_csr_pc",   k, o_csr_pc[k],      is_ex ? wb_pc : 32'h0);
      chk("wb_vaddr",    k, o_vaddr[k],       vaddr);
      chk("ertn_flush",  k, 32'(o_ertn[k]),   32'(!blocked && wb_valid && wb_ertn && !is_ex));
      chk("wb_commit",   k, 32'(o_commit[k]), 32'(!blocked && wb_valid && !is_ex));
      chk("pipe_flush",  k, 32'(o_flush[k]),  32'(blocked || ev));
      chk("redir_valid", k, 32'(o_rv[k]),     32'(m_wait[k]));
      chk("redir_pc",    k, o_rpc[k],         m_rpc[k]);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic blocked, is_ex, ev;
      blocked = m_wait[k] || (m_drain[k] > 0);
      is_ex   = !blocked && wb_valid && (has_int || (wb_exc != 5'd0));
      ev      = !blocked && wb_valid && (has_int || (wb_exc != 5'd0) || wb_ertn);
      if (!resetn) begin
        m_wait[k] = 1'b0; m_rpc[k] = 32'h0; m_drain[k] = 0;
      end else if (ev) begin
        m_wait[k] = 1'b1;
        m_rpc[k]  = is_ex ? ex_entry : ertn_entry;
      end else if (m_wait[k] && redirect_ready) begin
        m_wait[k]  = 1'b0;
        m_drain[k] = drain_of(k);
      end else if (m_drain[k] > 0) begin
        m_drain[k]--;
      end
    end
  endtask

  // Advance one clock (model follows the edge), then drive new inputs and check.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] va,
                      input logic [4:0] exc, input logic er, input logic hi,
                      input logic rdy, input logic rs);
    @(posedge clk);
    model_update();
    @(negedge clk);
    wb_valid = v; wb_pc = pc; wb_vaddr_in = va; wb_exc = exc;
    wb_ertn = er; has_int = hi; redirect_ready = rdy; resetn = rs;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 1'b0; m_rpc[k] = 32'h0; m_drain[k] = 0;
    end
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_redir_valid", 0, 32'(o_rv[0]), 32'h0);
    chk("rst_redir_pc", 0, o_rpc[0], 32'h0);

    // SYS event and its registered redirect
    step(1'b1, 32'h1C000100, 32'h0, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sys_ex", 0, 32'(o_ex[0]), 32'h1);
    chk("sys_ecode", 0, 32'(o_ecode[0]), 32'h0B);
    chk("sys_csr_pc", 0, o_csr_pc[0], 32'h1C000100);
    chk("sys_commit", 0, 32'(o_commit[0]), 32'h0);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sys_rv", 0, 32'(o_rv[0]), 32'h1);
    chk("sys_rpc", 0, o_rpc[0], 32'h1C008000);

    // Redirect held while ready is low; WB pulses must not commit
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h1C000300 + 32'(i * 4), 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("hold_commit", 0, 32'(o_commit[0]), 32'h0);
      chk("hold_rpc", 0, o_rpc[0], 32'h1C008000);
    end
    step(1'b1, 32'h1C000400, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h1C000404, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("drain1_flush", 0, 32'(o_flush[0]), 32'h1);
    chk("drain0_commit", 1, 32'(o_commit[1]), 32'h1);
    step(1'b1, 32'h1C000408, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("drain2_commit", 0, 32'(o_commit[0]), 32'h0);
    step(1'b1, 32'h1C00040C, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("post_drain_commit", 0, 32'(o_commit[0]), 32'h1);

    // Priority: INT over everything, then ADEF
    step(1'b1, 32'h1C000500, 32'h12345678, 5'b10101, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("int_ecode", 0, 32'(o_ecode[0]), 32'h00);
    chk("int_ex", 0, 32'(o_ex[0]), 32'h1);
    idle(4);
    step(1'b1, 32'h1C000504, 32'h12345678, 5'b10101, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("adef_ecode", 0, 32'(o_ecode[0]), 32'h08);
    chk("adef_vaddr", 0, o_vaddr[0], 32'h1C000504);
    idle(4);

    // ERTN alone, then ERTN with INE
    step(1'b1, 32'h1C000600, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("ertn_flush", 0, 32'(o_ertn[0]), 32'h1);
    chk("ertn_ex", 0, 32'(o_ex[0]), 32'h0);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ertn_rpc", 0, o_rpc[0], 32'h1C000200);
    idle(3);
    step(1'b1, 32'h1C000604, 32'h0, 5'b01000, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("ertn_ine_ecode", 0, 32'(o_ecode[0]), 32'h0D);
    chk("ertn_ine_flush", 0, 32'(o_ertn[0]), 32'h0);
    idle(4);

    // Reset during REDIRECT, then a fresh ALE
    step(1'b1, 32'h1C000700, 32'h0, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_rv", 0, 32'(o_rv[0]), 32'h0);
    step(1'b1, 32'h1C000704, 32'hDEADBEE1, 5'b00001, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ale_ecode", 0, 32'(o_ecode[0]), 32'h09);
    chk("ale_vaddr", 0, o_vaddr[0], 32'hDEADBEE1);
    idle(4);

    // Zero-drain build takes back-to-back exceptions
    step(1'b1, 32'h1C000800, 32'h0, 5'b00100, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h1C000804, 32'h0, 5'b00010, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("b2b_ex", 1, 32'(o_ex[1]), 32'h1);
    chk("b2b_ecode", 1, 32'(o_ecode[1]), 32'h0C);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ex_entry   = $urandom;
      ertn_entry = $urandom;
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 49) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
